// File: rtl/pix_ram_arbiter_pkg.sv
// pix_ram_arb_pkg: shared defaults and the rotate-right priority pick for the picture-memory arbiter
package pix_ram_arb_pkg;
   localparam int NREQ_DEF   = 4;
   localparam int SIZE_DEF   = 13;
   localparam int ADDR_W_DEF = 13;
   localparam int IDX_W      = $clog2(NREQ_DEF);
   localparam int MAXREQ     = 8;
   localparam int MAXW       = 3;

   function automatic int unsigned rr_index(input logic [MAXREQ-1:0] req, input int unsigned ptr,
                                            input int unsigned n);
      logic [MAXW-1:0] j;
      rr_index = ptr;
      for (int unsigned k = n; k > 0; k--) begin
         j = MAXW'((ptr + k - 1) % n);
         if (req[j]) rr_index = 32'(j);
      end
   endfunction
endpackage

// File: rtl/pix_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, first requester at or after ptr wins
module rr_pick import pix_ram_arb_pkg::*; #(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = IDX_W
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);
   logic [MAXREQ-1:0] req_ext;
   // widen the request vector, pick the winner index and one-hot it
   always_comb begin
      req_ext = '0;
      req_ext[NREQ-1:0] = req;
      idx = IW'(rr_index(req_ext, 32'(ptr), NREQ));
      gnt = '0;
      gnt[idx] = |req;
   end
endmodule

// File: rtl/pix_ram_arbiter.sv
// pix_ram_arbiter: round-robin sharing of the picture-memory RAM port; optional lock via RAM_ARB_LOCK_EN
module pix_ram_arbiter import pix_ram_arb_pkg::*; #(
   parameter int NREQ             = NREQ_DEF,
   parameter int SIZE             = SIZE_DEF,
   parameter int SIZE_address_pix = ADDR_W_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NREQ-1:0]                  req,
   input  logic [NREQ-1:0]                  req_we,
   input  logic [NREQ*SIZE_address_pix-1:0] req_addr,
   input  logic [NREQ*SIZE-1:0]             req_wdata,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NREQ-1:0]                  lock,
`endif
   output logic [NREQ-1:0]                  gnt,
   output logic [NREQ-1:0]                  rvalid,
   output logic [SIZE-1:0]                  rdata,
   output logic [SIZE_address_pix-1:0]      write_addressp,
   output logic [SIZE_address_pix-1:0]      read_addressp,
   output logic [SIZE-1:0]                  dp,
   output logic                             we_p,
   output logic                             re_p,
   input  logic [SIZE-1:0]                  qp
);
   localparam int IW = $clog2(NREQ);
   logic [IW-1:0] ptr, pidx, widx, owner;
   logic [NREQ-1:0] pgnt, rvalid_q;
   logic locked, wgnt;
   logic [SIZE_address_pix-1:0] waddr_q, raddr_q;
   logic [SIZE-1:0] dp_q;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(req), .ptr(ptr), .gnt(pgnt), .idx(pidx));

`ifdef RAM_ARB_LOCK_EN
   logic owner_v;
   assign locked = owner_v & req[owner] & lock[owner];
   // ownership is taken by a locking winner and kept while it holds both req and lock
   always_ff @(posedge clk)
      if (rst) begin
         owner_v <= 1'b0;
         owner <= '0;
      end else if (!locked) begin
         owner_v <= wgnt & lock[widx];
         owner <= widx;
      end
`else
   assign locked = 1'b0;
   assign owner = '0;
`endif

   // grant selection and RAM port drive; idle cycles hold the last driven address/data
   always_comb begin
      gnt = (rst || locked) ? '0 : pgnt;
      if (locked && !rst) gnt[owner] = 1'b1;
      widx = locked ? owner : pidx;
      wgnt = |gnt;
      we_p = wgnt & req_we[widx];
      re_p = wgnt & ~req_we[widx];
      write_addressp = we_p ? req_addr[widx*SIZE_address_pix +: SIZE_address_pix] : waddr_q;
      read_addressp = re_p ? req_addr[widx*SIZE_address_pix +: SIZE_address_pix] : raddr_q;
      dp = we_p ? req_wdata[widx*SIZE +: SIZE] : dp_q;
   end

   assign rvalid = rst ? '0 : rvalid_q;
   assign rdata = qp;

   // rotate pointer, remember port values and delay read grants to match the RAM's registered read
   always_ff @(posedge clk)
      if (rst) begin
         ptr <= '0;
         rvalid_q <= '0;
         waddr_q <= '0;
         raddr_q <= '0;
         dp_q <= '0;
      end else begin
         if (wgnt && !locked) ptr <= (widx == IW'(NREQ - 1)) ? '0 : widx + 1'b1;
         rvalid_q <= re_p ? gnt : '0;
         waddr_q <= write_addressp;
         raddr_q <= read_addressp;
         dp_q <= dp;
      end
endmodule

// File: tb/tb_pix_ram_arbiter.sv
// tb_pix_ram_arbiter: directed checks of pix_ram_arbiter against a behavioural RAM
module tb_pix_ram_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req = '0, req_we = '0;
   logic [51:0] req_addr = '0, req_wdata = '0;
   logic [3:0] gnt, rvalid;
   logic [12:0] rdata, write_addressp, read_addressp, dp, qp;
   logic we_p, re_p;
   logic [12:0] mem [0:8191];
   int checks = 0, passes = 0;
`ifdef RAM_ARB_LOCK_EN
   logic [3:0] lock = '0;
`endif

   pix_ram_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RAM_ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .write_addressp(write_addressp),
      .read_addressp(read_addressp), .dp(dp), .we_p(we_p), .re_p(re_p), .qp(qp)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we_p) mem[write_addressp] <= dp;
      if (re_p) qp <= mem[read_addressp];
   end

   function automatic logic [12:0] pat(input int a);
      return 13'((a * 37 + 5) % 8192);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      req_we = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      req_we = '0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else passes++;
      checks++; if ({we_p, re_p} !== 2'b00) $display("FAIL reset_we_re got %b want 00", {we_p, re_p}); else passes++;
      checks++; if (rvalid !== 4'b0000) $display("FAIL reset_rvalid got %b want 0000", rvalid); else passes++;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) $display("FAIL reset_first_gnt got %b want 0001", gnt); else passes++;
      step();
   endtask

   task automatic test_fairness();
      logic [3:0] eg, ev;
      do_reset();
      for (int i = 0; i < 4; i++) req_addr[i*13 +: 13] = 13'(10 + i);
      req = 4'b1111;
      for (int c = 0; c < 9; c++) begin
         if (c == 8) req = '0;
         @(negedge clk);
         eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
         ev = (c > 0) ? 4'(1 << ((c - 1) % 4)) : 4'b0000;
         checks++; if (gnt !== eg) $display("FAIL fair_gnt c=%0d got %b want %b", c, gnt, eg); else passes++;
         checks++; if (rvalid !== ev) $display("FAIL fair_rvalid c=%0d got %b want %b", c, rvalid, ev); else passes++;
         if (c > 0) begin
            checks++;
            if (rdata !== pat(10 + (c - 1) % 4)) $display("FAIL fair_rdata c=%0d got %h want %h", c, rdata, pat(10 + (c - 1) % 4));
            else passes++;
         end
         step();
      end
   endtask

   task automatic test_skip_idle();
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b1001;
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) $display("FAIL skip_gnt3 got %b want 1000", gnt); else passes++;
      step();
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) $display("FAIL skip_gnt0 got %b want 0001", gnt); else passes++;
      step();
      req = 4'b1111;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) $display("FAIL skip_ptr1 got %b want 0010", gnt); else passes++;
      step();
   endtask

   task automatic test_write_read();
      do_reset();
      req = 4'b0001;
      req_we = 4'b0001;
      req_addr[0 +: 13] = 13'd100;
      req_wdata[0 +: 13] = 13'h0ABC;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) $display("FAIL wr_gnt got %b want 0001", gnt); else passes++;
      checks++; if ({we_p, re_p} !== 2'b10) $display("FAIL wr_we_re got %b want 10", {we_p, re_p}); else passes++;
      checks++; if (write_addressp !== 13'd100) $display("FAIL wr_addr got %0d want 100", write_addressp); else passes++;
      checks++; if (dp !== 13'h0ABC) $display("FAIL wr_dp got %h want 0abc", dp); else passes++;
      step();
      req = 4'b0010;
      req_we = '0;
      req_addr[13 +: 13] = 13'd100;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) $display("FAIL rd_gnt got %b want 0010", gnt); else passes++;
      checks++; if ({we_p, re_p} !== 2'b01) $display("FAIL rd_we_re got %b want 01", {we_p, re_p}); else passes++;
      checks++; if (read_addressp !== 13'd100) $display("FAIL rd_addr got %0d want 100", read_addressp); else passes++;
      step();
      req = '0;
      @(negedge clk);
      checks++; if (rvalid !== 4'b0010) $display("FAIL rd_rvalid got %b want 0010", rvalid); else passes++;
      checks++; if (rdata !== 13'h0ABC) $display("FAIL rd_rdata got %h want 0abc", rdata); else passes++;
      checks++; if (write_addressp !== 13'd100) $display("FAIL idle_hold_waddr got %0d want 100", write_addressp); else passes++;
      checks++; if (dp !== 13'h0ABC) $display("FAIL idle_hold_dp got %h want 0abc", dp); else passes++;
      step();
   endtask

   task automatic test_mid_reset();
      do_reset();
      req = 4'b0001;
      req_we = '0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) $display("FAIL mid_gnt got %b want 0001", gnt); else passes++;
      step();
      req = '0;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (rvalid !== 4'b0000) $display("FAIL mid_rvalid_rst got %b want 0000", rvalid); else passes++;
      step();
      rst = 1'b0;
      req = 4'b1111;
      @(negedge clk);
      checks++; if (rvalid !== 4'b0000) $display("FAIL mid_rvalid_after got %b want 0000", rvalid); else passes++;
      checks++; if (gnt !== 4'b0001) $display("FAIL mid_ptr0 got %b want 0001", gnt); else passes++;
      step();
   endtask

`ifdef RAM_ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      req = 4'b0010;
      step();
      req = 4'b1111;
      lock = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (gnt !== 4'b0100) $display("FAIL lock_gnt c=%0d got %b want 0100", c, gnt); else passes++;
         step();
      end
      lock = '0;
      @(negedge clk);
      checks++; if (gnt !== 4'b1000) $display("FAIL lock_release got %b want 1000", gnt); else passes++;
      step();
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) $display("FAIL lock_next got %b want 0001", gnt); else passes++;
      step();
      req = '0;
   endtask
`endif

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = pat(a);
      test_reset();
      test_fairness();
      test_skip_idle();
      test_write_read();
      test_mid_reset();
`ifdef RAM_ARB_LOCK_EN
      test_lock();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
